// File: rtl/sram_arb_pkg.sv
// Shared defaults and helpers for the scratch-SRAM port arbiter.
// The read latency sets the depth of the response tag pipeline.
package sram_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int AW_DEF      = 12;
  localparam int DW_DEF      = 128;
  localparam int RD_LATENCY  = 2;

  // Index of the set bit in a one-hot vector of up to 8 bits; 0 when none is set.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps, the first requester found wins.
// The pointer moves past the winner only when upd_i allows the grant to take effect.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [N-1:0]  req_i,
  input  logic          upd_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q;

  always_comb begin
    int            pos;
    logic [IW-1:0] pidx;
    logic          found;
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    pidx  = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= N) pos = pos - N;
      pidx = IW'(pos);
      if (!found && req_i[pidx]) begin
        gnt_o[pidx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_o     = |req_i;
  assign gnt_idx_o = IW'(onehot2idx(8'(gnt_o)));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ptr_q <= '0;
    end else if (upd_i && any_o) begin
      ptr_q <= (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a dual-port scratch SRAM (A = write, B = read) between NUM_REQ requesters.
// Handshake: a request is taken in the cycle where req_valid[i] & req_ready[i]; responses have no backpressure.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                  clka,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  sram_ena,
  output logic                  sram_wea,
  output logic [AW-1:0]         sram_addra,
  output logic [DW-1:0]         sram_dina,
  output logic                  sram_enb,
  output logic [AW-1:0]         sram_addrb,
  input  logic [DW-1:0]         sram_doutb
);

  localparam int IW = $clog2(NUM_REQ);

  logic [AW-1:0]      addr_arr [NUM_REQ];
  logic [DW-1:0]      data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [IW-1:0]      wr_idx, rd_idx;
  logic               wr_any, rd_any;
  logic               collision, wr_go, rd_go;

  logic               ena_q, wea_q, enb_q;
  logic [AW-1:0]      addra_q, addrb_q;
  logic [DW-1:0]      dina_q;
  logic [NUM_REQ-1:0] tag_q [RD_LATENCY];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*AW +: AW];
    assign data_arr[g] = req_wdata[g*DW +: DW];
  end

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk_i     (clka),
    .rstn_i    (rstn),
    .req_i     (req_valid & req_we),
    .upd_i     (1'b1),
    .gnt_o     (wr_gnt),
    .gnt_idx_o (wr_idx),
    .any_o     (wr_any)
  );

  // A read losing to a same-address write holds its pointer so it retries next cycle.
  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk_i     (clka),
    .rstn_i    (rstn),
    .req_i     (req_valid & ~req_we),
    .upd_i     (~collision),
    .gnt_o     (rd_gnt),
    .gnt_idx_o (rd_idx),
    .any_o     (rd_any)
  );

  assign collision = wr_any && rd_any && (addr_arr[wr_idx] == addr_arr[rd_idx]);
  assign wr_go     = wr_any && rstn;
  assign rd_go     = rd_any && !collision && rstn;
  assign req_ready = ({NUM_REQ{wr_go}} & wr_gnt) | ({NUM_REQ{rd_go}} & rd_gnt);

  always_ff @(posedge clka) begin
    if (!rstn) begin
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      enb_q   <= 1'b0;
      addra_q <= '0;
      addrb_q <= '0;
      dina_q  <= '0;
      for (int s = 0; s < RD_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      ena_q <= wr_go;
      wea_q <= wr_go;
      enb_q <= rd_go;
      if (wr_go) begin
        addra_q <= addr_arr[wr_idx];
        dina_q  <= data_arr[wr_idx];
      end
      if (rd_go) addrb_q <= addr_arr[rd_idx];
      tag_q[0] <= rd_go ? rd_gnt : '0;
      for (int s = 1; s < RD_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign sram_ena   = ena_q;
  assign sram_wea   = wea_q;
  assign sram_addra = addra_q;
  assign sram_dina  = dina_q;
  assign sram_enb   = enb_q;
  assign sram_addrb = addrb_q;

  // The tag leaves the pipeline in the same cycle the SRAM's registered doutb is valid.
  assign rsp_valid = tag_q[RD_LATENCY-1];
  assign rsp_data  = (|tag_q[RD_LATENCY-1]) ? sram_doutb : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, round-robin reference model and response scoreboard.
// Directed scenarios first, then a randomized phase with occasional resets.
module tb_sram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 128;
  localparam int W  = N + DW;

  logic              clka;
  logic              rstn;
  logic [N-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rsp_data, sram_dina, sram_doutb;
  logic              sram_ena, sram_wea, sram_enb;
  logic [AW-1:0]     sram_addra, sram_addrb;

  // ---------------- clock / reset ----------------
  initial clka = 1'b0;
  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  sram_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clka       (clka),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .sram_ena   (sram_ena),
    .sram_wea   (sram_wea),
    .sram_addra (sram_addra),
    .sram_dina  (sram_dina),
    .sram_enb   (sram_enb),
    .sram_addrb (sram_addrb),
    .sram_doutb (sram_doutb)
  );

  // Behavioural SRAM with registered read port.
  logic [DW-1:0] sram_mem [4096];
  always @(posedge clka) begin
    if (sram_ena && sram_wea) sram_mem[sram_addra] <= sram_dina;
    if (sram_enb) sram_doutb <= sram_mem[sram_addrb];
  end

  // ---------------- stimulus and reference model state ----------------
  logic [N-1:0]  s_valid, s_we;
  logic          s_rstn;
  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_data [N];

  logic [DW-1:0] mmem [4096];
  int            wptr, rptr;
  int            prev_w, prev_r;
  logic [AW-1:0] prev_waddr, prev_raddr;
  logic [DW-1:0] prev_wdata;
  bit            primed;

  logic [W-1:0]  exp_q [$];
  int            exp_cyc_q [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // First candidate at or after ptr, wrapping; -1 if none.
  function automatic int rr_pick(input logic [N-1:0] cand, input int ptr);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (ptr + k) % N;
      if (cand[p]) return p;
    end
    return -1;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    int           w, r;
    logic [N-1:0] exp_ready, oh;
    @(negedge clka);
    rstn      = s_rstn;
    req_valid = s_valid;
    req_we    = s_we;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = s_addr[i];
      req_wdata[i*DW +: DW] = s_data[i];
    end
    #1;
    if (primed) begin
      chk("sram_ena", W'(sram_ena), W'(prev_w >= 0));
      chk("sram_wea", W'(sram_wea), W'(prev_w >= 0));
      chk("sram_enb", W'(sram_enb), W'(prev_r >= 0));
      if (prev_w >= 0) begin
        chk("sram_addra", W'(sram_addra), W'(prev_waddr));
        chk("sram_dina", W'(sram_dina), W'(prev_wdata));
      end
      if (prev_r >= 0) chk("sram_addrb", W'(sram_addrb), W'(prev_raddr));
    end
    if (!s_rstn) begin
      w = -1;
      r = -1;
      wptr = 0;
      rptr = 0;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
      end
      primed = 1'b1;
    end else begin
      w = rr_pick(s_valid & s_we, wptr);
      r = rr_pick(s_valid & ~s_we, rptr);
      if (w >= 0 && r >= 0 && s_addr[w] == s_addr[r]) r = -1;
    end
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    if (r >= 0) exp_ready[r] = 1'b1;
    chk("req_ready", W'(req_ready), W'(exp_ready));
    if (w >= 0) begin
      mmem[s_addr[w]] = s_data[w];
      wptr = (w + 1) % N;
      prev_waddr = s_addr[w];
      prev_wdata = s_data[w];
    end
    if (r >= 0) begin
      oh = '0;
      oh[r] = 1'b1;
      exp_q.push_back({oh, mmem[s_addr[r]]});
      exp_cyc_q.push_back(cyc + 2);
      rptr = (r + 1) % N;
      prev_raddr = s_addr[r];
    end
    prev_w = w;
    prev_r = r;
  endtask

  task automatic idle(input int n);
    s_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    int           c;
    forever begin
      @(negedge clka);
      #3;
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected @cyc %0d: got rsp_valid %b expected none", cyc, rsp_valid);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("rsp_latency", W'(cyc), W'(c));
          chk("rsp_vld_data", {rsp_valid, rsp_data}, e);
        end
      end else if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing @cyc %0d: got no rsp_valid expected %0h", cyc, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    rstn = 1'b0;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    sram_doutb = '0;
    s_rstn = 1'b0;
    s_valid = '0;
    s_we = '0;
    primed = 1'b0;
    wptr = 0;
    rptr = 0;
    prev_w = -1;
    prev_r = -1;
    prev_waddr = '0;
    prev_raddr = '0;
    prev_wdata = '0;
    for (int a = 0; a < 4096; a++) begin
      sram_mem[a] = '0;
      mmem[a] = '0;
    end
    for (int i = 0; i < N; i++) begin
      s_addr[i] = AW'(12'h100 + i);
      s_data[i] = {$urandom, $urandom, $urandom, $urandom};
    end

    // T1: reset held 3 cycles with every requester asking to write.
    s_valid = '1;
    s_we    = '1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_ready", W'(req_ready), '0);
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_rsp_data", W'(rsp_data), '0);
    chk("rst_ena_wea_enb", W'({sram_ena, sram_wea, sram_enb}), '0);
    chk("rst_addra", W'(sram_addra), '0);
    chk("rst_addrb", W'(sram_addrb), '0);
    chk("rst_dina", W'(sram_dina), '0);

    // T2: continuous writes from all four -> grants 0,1,2,3,0,...
    s_rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < N; j++) s_data[j] = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("t2_order", W'(req_ready), W'(1 << (i % N)));
      if (i > 0) chk("t2_addra", W'(sram_addra), W'(12'h100 + ((i - 1) % N)));
    end
    idle(2);

    // T3: write 0xAA.. at 0x010 by req1, then read it by req2.
    s_valid = 4'b0010;
    s_we = 4'b0010;
    s_addr[1] = 12'h010;
    s_data[1] = {16{8'hAA}};
    step();
    s_valid = 4'b0100;
    s_we = 4'b0000;
    s_addr[2] = 12'h010;
    step();
    chk("t3_ready", W'(req_ready), W'(4'b0100));
    idle(3);

    // T4: same-address write and read in one cycle; the read waits a cycle.
    s_valid = 4'b1001;
    s_we = 4'b0001;
    s_addr[0] = 12'h123;
    s_addr[3] = 12'h123;
    s_data[0] = {16{8'h55}};
    step();
    chk("t4_collide_ready", W'(req_ready), W'(4'b0001));
    s_valid = 4'b1000;
    step();
    chk("t4_retry_ready", W'(req_ready), W'(4'b1000));
    idle(3);

    // T5: write and read on different addresses in parallel.
    s_valid = 4'b0011;
    s_we = 4'b0001;
    s_addr[0] = 12'h001;
    s_addr[1] = 12'h002;
    step();
    chk("t5_ready", W'(req_ready), W'(4'b0011));
    idle(1);
    chk("t5_ena_enb", W'({sram_ena, sram_enb}), W'(2'b11));
    idle(3);

    // T6: reset right after a read grant drops the response.
    s_valid = 4'b0100;
    s_we = 4'b0000;
    s_addr[2] = 12'h010;
    step();
    s_valid = '0;
    s_rstn = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      s_rstn = (i >= 1);
      step();
      chk("t6_no_rsp", W'(rsp_valid), '0);
    end

    // Randomized traffic on a small address window to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      s_rstn = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < N; i++) begin
        s_valid[i] = 1'($urandom_range(0, 3) != 0);
        s_we[i]    = 1'($urandom_range(0, 1));
        s_addr[i]  = AW'($urandom_range(0, 7));
        s_data[i]  = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    s_rstn = 1'b1;
    idle(4);
    chk("drain_empty", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
